decimating_block_accumulator: RTL and testbench
===============================================

Name: decimating_block_accumulator

Overview:
- Upstream stage of the dynamic-precision rounder.
- Sums blocks of N = 2^log2_n input samples, with N selectable at run time.
- Emits each block sum once, as a full-width word, with its valid bit growth reported on current_precision.
- The downstream rounder uses current_precision to align the sum and round it back to the system width, so this block never truncates or saturates.

Parameters:
- WIDTH_IN, 16, width of input samples.
- LOG2_N_MAX, 3, largest supported log2 block length (N up to 8).
- WIDTH_OUT_MAX, WIDTH_IN+LOG2_N_MAX (19), physical width of dout; must equal the downstream rounder's maximum input width.
- IS_SIGNED, 1, 1 = two's-complement samples and sums; 0 = unsigned.

Ports:
- clk, input, 1, single system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, input sample valid; din is consumed only on cycles where ena=1.
- log2_n, input, 8, requested log2 block length; values above LOG2_N_MAX are clamped to LOG2_N_MAX.
- din, input, WIDTH_IN, input sample.
- dout, output, WIDTH_OUT_MAX, block sum, LSB-aligned and sign/zero-extended to full width.
- dout_valid, output, 1, one-cycle pulse marking a new dout.
- current_precision, output, 8, valid bit width of dout (WIDTH_IN + block log2_n).

Behaviour:
- Reset (async assert, sync release). Values during reset and after release:
  - dout = 0, dout_valid = 0, current_precision = WIDTH_IN.
  - Internal accumulator = 0, sample counter = 0, latched block length = 0.
- States: IDLE (counter = 0, no partial block) and ACCUM (partial block held).
- IDLE + ena:
  - Latch clamped log2_n as the block length L.
  - acc <= din (extended to WIDTH_OUT_MAX); counter <= 1.
  - If L = 0: the block completes on this same sample (see completion rule); stay in IDLE.
- ACCUM + ena: acc <= acc + din; counter <= counter + 1.
- ACCUM + !ena: hold all state. Gaps of any length are allowed.
- Completion: on the cycle the 2^L-th sample is accepted:
  - Register dout <= acc + din, current_precision <= WIDTH_IN + L, dout_valid <= 1.
  - Clear acc and counter; return to IDLE.
  - The next cycle may start a new block; back-to-back blocks have no dead cycle.
- Latency: dout_valid rises exactly 1 clock after the final sample of a block is accepted.
- dout and current_precision hold their values until the next completion. dout_valid is high for exactly 1 cycle per block.
- log2_n is sampled only when a block starts. Changes mid-block take effect at the next block.
- Arithmetic:
  - IS_SIGNED=1: din is sign-extended and sums are signed.
  - IS_SIGNED=0: din is zero-extended.
  - WIDTH_OUT_MAX bits hold any 2^LOG2_N_MAX-sample sum, so no overflow or saturation logic is required.
  - Bits of dout above current_precision are pure sign/zero extension.
- Reset mid-block discards the partial sum. No output is produced for the discarded block.

Optional Feature:
- Macro: DECIM_ACC_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 synchronously clears acc and counter, returns to IDLE, and emits no output for the partial block.
  - flush has priority over ena in the same cycle: that cycle's din is dropped.
  - dout, dout_valid and current_precision are unaffected, except that a completion due on the flush cycle is suppressed.
- Undefined: no flush port; a partial block can only be discarded by rst_n.

Test Plan:
- IS_SIGNED=1, log2_n=2, ena on 4 consecutive cycles with din = 100, 200, 300, 400 -> one cycle after the 4th sample: dout=1000, current_precision=18, dout_valid pulse of 1 cycle.
- log2_n=3, 8 samples of -32768 (with ena gaps of 2 cycles between samples) -> dout = -262144 (19'h40000), current_precision=19, one valid pulse only.
- log2_n=0, din = 5 then -7 on consecutive cycles -> dout=5 then -7 on the following two cycles, dout_valid high for both, current_precision=16.
- Start block with log2_n=1; set log2_n=2 after the first sample; supply 6 samples of value 1 -> outputs 2 (precision 17) then 4 (precision 18).
- log2_n=2, 3 samples of 1000, pull rst_n low for 1 cycle mid-clock -> outputs go to 0/0/16 immediately; after release, 4 samples of 1 -> dout=4, with no residue from the aborted block.
- IS_SIGNED=0, log2_n=3, 8 samples of 16'hFFFF -> dout=19'h7FFF8, current_precision=19.
- With DECIM_ACC_FLUSH_EN: log2_n=2, 2 samples of 10, flush, then 4 samples of 1 -> single output dout=4.

Source files
------------

// File: rtl/decimating_block_accumulator.sv
// Block-sum decimator: adds 2^L samples (L latched per block) and emits one full-width sum.
// Optional macro DECIM_ACC_FLUSH_EN adds a synchronous flush that discards the partial block.
module decimating_block_accumulator #(
  parameter int WIDTH_IN      = 16,
  parameter int LOG2_N_MAX    = 3,
  parameter int WIDTH_OUT_MAX = WIDTH_IN + LOG2_N_MAX,
  parameter bit IS_SIGNED     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
`ifdef DECIM_ACC_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic [7:0]               log2_n,
  input  logic [WIDTH_IN-1:0]      din,
  output logic [WIDTH_OUT_MAX-1:0] dout,
  output logic                     dout_valid,
  output logic [7:0]               current_precision
);

  localparam int L_W   = (LOG2_N_MAX > 0) ? $clog2(LOG2_N_MAX + 1) : 1;
  localparam int CNT_W = LOG2_N_MAX + 1;
  localparam int EXT_W = WIDTH_OUT_MAX - WIDTH_IN;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic signed [WIDTH_OUT_MAX-1:0] extend_in(input logic [WIDTH_IN-1:0] x);
    logic fill;
    fill = IS_SIGNED ? x[WIDTH_IN-1] : 1'b0;
    return {{EXT_W{fill}}, x};
  endfunction

  function automatic logic [L_W-1:0] clamp_log2(input logic [7:0] req);
    if (req > 8'(LOG2_N_MAX)) return L_W'(LOG2_N_MAX);
    return req[L_W-1:0];
  endfunction

  state_t                           state_q, state_d;
  logic signed [WIDTH_OUT_MAX-1:0]  acc_p0, acc_d, sum;
  logic [CNT_W-1:0]                 cnt_p0, cnt_d, blk_len;
  logic [L_W-1:0]                   len_p0, len_d, eff_len;
  logic                             drop, done;

  logic signed [WIDTH_OUT_MAX-1:0]  dout_p1;
  logic [7:0]                       prec_p1;
  logic                             vld_p1;

`ifdef DECIM_ACC_FLUSH_EN
  assign drop = flush;
`else
  assign drop = 1'b0;
`endif

  // The block length is only taken from log2_n when a new block opens.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_p0;
    cnt_d   = cnt_p0;
    len_d   = len_p0;
    done    = 1'b0;
    eff_len = (state_q == IDLE) ? clamp_log2(log2_n) : len_p0;
    blk_len = CNT_W'(1) << eff_len;
    sum     = ((state_q == IDLE) ? '0 : acc_p0) + extend_in(din);
    if (drop) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (ena) begin
      len_d = eff_len;
      if (cnt_p0 + CNT_W'(1) == blk_len) begin
        done    = 1'b1;
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum;
        cnt_d   = cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Stage p0: accumulator, sample counter, latched length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_p0  <= '0;
      cnt_p0  <= '0;
      len_p0  <= '0;
    end else begin
      state_q <= state_d;
      acc_p0  <= acc_d;
      cnt_p0  <= cnt_d;
      len_p0  <= len_d;
    end
  end

  // Stage p1: registered block result, held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= '0;
      prec_p1 <= 8'(WIDTH_IN);
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= done;
      if (done) begin
        dout_p1 <= sum;
        prec_p1 <= 8'(WIDTH_IN) + 8'(eff_len);
      end
    end
  end

  assign dout              = dout_p1;
  assign dout_valid        = vld_p1;
  assign current_precision = prec_p1;

endmodule

// File: tb/tb_decimating_block_accumulator.sv
// Bench for decimating_block_accumulator: signed and unsigned instances share stimulus
// and are checked every cycle against an arithmetic block-sum reference model.
module tb_decimating_block_accumulator;

`ifdef DECIM_ACC_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        flush;
  logic [7:0]  log2_n;
  logic [15:0] din;
  logic [18:0] dout_s, dout_u;
  logic        vld_s, vld_u;
  logic [7:0]  prec_s, prec_u;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          ms_sum, mu_sum, m_cnt, m_l;
  logic [18:0] e_dout_s, e_dout_u;
  logic        e_vld;
  logic [7:0]  e_prec;

  always #5 clk = ~clk;

  decimating_block_accumulator #(.WIDTH_IN(16), .LOG2_N_MAX(3), .WIDTH_OUT_MAX(19), .IS_SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef DECIM_ACC_FLUSH_EN
    .flush(flush),
`endif
    .log2_n(log2_n), .din(din),
    .dout(dout_s), .dout_valid(vld_s), .current_precision(prec_s)
  );

  decimating_block_accumulator #(.WIDTH_IN(16), .LOG2_N_MAX(3), .WIDTH_OUT_MAX(19), .IS_SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef DECIM_ACC_FLUSH_EN
    .flush(flush),
`endif
    .log2_n(log2_n), .din(din),
    .dout(dout_u), .dout_valid(vld_u), .current_precision(prec_u)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_vld_s"},  32'(vld_s),  32'(e_vld));
    check({tag, "_vld_u"},  32'(vld_u),  32'(e_vld));
    check({tag, "_dout_s"}, 32'(dout_s), 32'(e_dout_s));
    check({tag, "_dout_u"}, 32'(dout_u), 32'(e_dout_u));
    check({tag, "_prec_s"}, 32'(prec_s), 32'(e_prec));
    check({tag, "_prec_u"}, 32'(prec_u), 32'(e_prec));
  endtask

  task automatic model_reset();
    ms_sum = 0; mu_sum = 0; m_cnt = 0; m_l = 0;
    e_dout_s = '0; e_dout_u = '0; e_vld = 1'b0; e_prec = 8'd16;
  endtask

  // One clock: drive inputs, advance the model by the accepted sample, compare.
  task automatic step(input string tag, input logic e, input logic [15:0] d,
                      input logic [7:0] l, input logic f);
    int sv;
    bit fl;
    fl     = f & HAS_FLUSH;
    ena    = e;
    din    = d;
    log2_n = l;
    flush  = fl;
    @(posedge clk);
    #1;
    e_vld = 1'b0;
    if (fl) begin
      ms_sum = 0; mu_sum = 0; m_cnt = 0;
    end else if (e) begin
      if (m_cnt == 0) m_l = (l > 8'd3) ? 3 : int'(l);
      sv     = $signed(d);
      ms_sum = ms_sum + sv;
      mu_sum = mu_sum + int'(d);
      m_cnt  = m_cnt + 1;
      if (m_cnt == (1 << m_l)) begin
        e_dout_s = 19'(ms_sum);
        e_dout_u = 19'(mu_sum);
        e_prec   = 8'(16 + m_l);
        e_vld    = 1'b1;
        ms_sum = 0; mu_sum = 0; m_cnt = 0;
      end
    end
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; flush = 1'b0; log2_n = 8'd0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) step("blk4", 1'b1, 16'(100 * (i + 1)), 8'd2, 1'b0);
    step("blk4_after", 1'b0, 16'd0, 8'd2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step("min8", 1'b1, 16'h8000, 8'd3, 1'b0);
      step("min8_gap", 1'b0, 16'h1234, 8'd0, 1'b0);
      step("min8_gap", 1'b0, 16'h4321, 8'd1, 1'b0);
    end

    step("n1_a", 1'b1, 16'd5, 8'd0, 1'b0);
    step("n1_b", 1'b1, 16'hFFF9, 8'd0, 1'b0);
    step("n1_idle", 1'b0, 16'd0, 8'd0, 1'b0);

    step("chg_l", 1'b1, 16'd1, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) step("chg_l", 1'b1, 16'd1, 8'd2, 1'b0);

    for (int i = 0; i < 3; i++) step("abort", 1'b1, 16'd1000, 8'd2, 1'b0);
    ena = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst", 1'b1, 16'd1, 8'd2, 1'b0);

    for (int i = 0; i < 8; i++) step("ffff8", 1'b1, 16'hFFFF, 8'd3, 1'b0);
    step("clamp_open", 1'b1, 16'd7, 8'd200, 1'b0);
    for (int i = 0; i < 7; i++) step("clamp", 1'b1, 16'd7, 8'd0, 1'b0);

    if (HAS_FLUSH) begin
      for (int i = 0; i < 2; i++) step("fl_part", 1'b1, 16'd10, 8'd2, 1'b0);
      step("fl_do", 1'b1, 16'd99, 8'd2, 1'b1);
      for (int i = 0; i < 4; i++) step("fl_post", 1'b1, 16'd1, 8'd2, 1'b0);
      for (int i = 0; i < 3; i++) step("fl_last", 1'b1, 16'd3, 8'd2, 1'b0);
      step("fl_due", 1'b1, 16'd3, 8'd2, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic [7:0] l;
      logic       f;
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      f = ($urandom_range(0, 29) == 0);
      step("rand", e, 16'($urandom), l, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
